pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 96, width of datapath payload (PC, imm, operands, indices).
REQ-002 SHALL have parameter CTRL_W, default 13, width of control payload squashed on flush/bubble.
REQ-003 SHALL have parameter CNT_W, default 16, width of performance counters.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream entry offered.
REQ-007 SHALL have port in_ready  output  1  stage can accept an entry.
REQ-008 SHALL have port in_ctrl  input  CTRL_W  upstream control word.
REQ-009 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-010 SHALL have port flush  input  1  synchronous squash of all held and incoming entries.
REQ-011 SHALL have port out_valid  output  1  entry presented downstream.
REQ-012 SHALL have port out_ready  input  1  downstream accepts.
REQ-013 SHALL have ports out_ctrl (CTRL_W) and out_data (DATA_W), outputs, head entry.
REQ-014 SHALL have, with PIPE_STAGE_PERF_EN only, outputs stall_cnt and flush_cnt, CNT_W each.

Function
REQ-015 SHALL hold up to two entries: main register M (drives outputs) and skid register S.
REQ-016 SHALL use states EMPTY (none), ONE (M valid), TWO (M and S valid); out_valid = state != EMPTY.
REQ-017 SHALL drive in_ready from a flop: high iff state != TWO and rst low; no combinational path from out_ready.
REQ-018 SHALL define push = in_valid & in_ready & ~flush; pop = out_valid & out_ready.
REQ-019 SHALL transition EMPTY: push -> ONE, M <= in.
REQ-020 SHALL transition ONE: push&pop -> ONE, M <= in; pop only -> EMPTY; push only -> TWO, S <= in; neither -> hold.
REQ-021 SHALL transition TWO: pop -> ONE, M <= S; no pop -> hold (push impossible).
REQ-022 SHALL give 1-cycle latency: push into EMPTY yields out_valid next cycle.
REQ-023 SHALL sustain one transfer per cycle while out_ready held high, and preserve strict FIFO order.
REQ-024 SHALL, on flush, go to EMPTY next cycle regardless of state, discarding M, S and any same-cycle input; flush wins over push and pop.
REQ-025 SHALL force out_ctrl to zero whenever out_valid is low (bubble = NOP control); out_data is don't-care then.
REQ-026 SHALL keep out_ctrl/out_data stable while out_valid & ~out_ready.

Reset
REQ-027 SHALL, while rst high, hold state EMPTY, out_valid 0, out_ctrl 0, out_data 0, in_ready 0, counters 0.
REQ-028 SHALL assert in_ready on the first rising edge after rst deasserts; rst mid-operation discards all entries immediately.

Configuration
REQ-029 SHALL, with macro PIPE_STAGE_PERF_EN defined, add stall_cnt (cycles with out_valid & ~out_ready) and flush_cnt (flush cycles with state != EMPTY), each saturating at 2^CNT_W-1.
REQ-030 SHALL, without PIPE_STAGE_PERF_EN, omit those ports and counters entirely; datapath behaviour identical.

Verification
REQ-031 SHALL test streaming: out_ready=1, push ctrl 0x001..0x00A on 10 consecutive cycles -> same 10 entries out in order, one per cycle, first one cycle after first push.
REQ-032 SHALL test backpressure: push A,B with out_ready=0 -> in_ready=0 after B, out shows A stable; out_ready=1 -> A then B, in_ready=1 one cycle after A pops.
REQ-033 SHALL test flush: state TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, incoming entry never appears.
REQ-034 SHALL test reset mid-stream: rst pulsed with state ONE -> out_valid=0, out_ctrl=0, out_data=0 at once; in_ready=1 one edge after release.
REQ-035 SHALL test perf (PIPE_STAGE_PERF_EN, CNT_W=4): 20 stalled cycles -> stall_cnt=15; 3 flushes of non-empty stage -> flush_cnt=3.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Two-entry pipeline stage with a main register (M) that drives the outputs
//   and a skid register (S) that absorbs one entry while downstream stalls.
//   in_ready is taken straight from a flop, so there is no combinational path
//   from out_ready back to in_ready.
//
//   Optional feature: define PIPE_STAGE_PERF_EN to add saturating performance
//   counters (stall_cnt, flush_cnt). Without the macro those ports and the
//   counters are absent and the datapath behaves identically.
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 13,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // Occupancy states: ST_ONE means M holds the head, ST_TWO means S also holds
  // the entry behind it.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e              state_q;
  state_e              state_d;

  logic                in_ready_q;
  logic                in_ready_d;
  logic                out_valid_q;
  logic                out_valid_d;

  logic [CTRL_W-1:0]   m_ctrl_q;
  logic [CTRL_W-1:0]   m_ctrl_d;
  logic [DATA_W-1:0]   m_data_q;
  logic [DATA_W-1:0]   m_data_d;
  logic [CTRL_W-1:0]   s_ctrl_q;
  logic [CTRL_W-1:0]   s_ctrl_d;
  logic [DATA_W-1:0]   s_data_q;
  logic [DATA_W-1:0]   s_data_d;

  logic                push_s;
  logic                pop_s;

  // Handshake qualifiers; flush suppresses the push here and overrides any
  // pop through the next-state logic.
  assign push_s = in_valid & in_ready_q & ~flush;
  assign pop_s  = out_valid_q & out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: occupancy follows push/pop, flush always empties.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (push_s) begin
          state_d = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (push_s && !pop_s) begin
          state_d = ST_TWO;
        end else if (!push_s && pop_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_TWO: begin
        if (pop_s) begin
          state_d = ST_ONE;
        end else begin
          state_d = ST_TWO;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_d;
    end
  end

  // Output decode from the next state so the handshake outputs can be flopped.
  always_comb begin
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // Handshake output registers; in_ready stays low throughout reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Datapath steering for M and S; M control is squashed whenever the stage
  // will be empty so the outputs present a NOP bubble.
  always_comb begin
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    case (state_q)
      ST_EMPTY: begin
        if (push_s) begin
          m_ctrl_d = in_ctrl;
          m_data_d = in_data;
        end else begin
          m_ctrl_d = m_ctrl_q;
        end
      end
      ST_ONE: begin
        if (push_s && pop_s) begin
          m_ctrl_d = in_ctrl;
          m_data_d = in_data;
        end else if (push_s) begin
          s_ctrl_d = in_ctrl;
          s_data_d = in_data;
        end else begin
          m_ctrl_d = m_ctrl_q;
        end
      end
      ST_TWO: begin
        if (pop_s) begin
          m_ctrl_d = s_ctrl_q;
          m_data_d = s_data_q;
        end else begin
          m_ctrl_d = m_ctrl_q;
        end
      end
      default: begin
        m_ctrl_d = {CTRL_W{1'b0}};
      end
    endcase
    if (state_d == ST_EMPTY) begin
      m_ctrl_d = {CTRL_W{1'b0}};
    end else begin
      m_ctrl_d = m_ctrl_d;
    end
  end

  // Main and skid payload registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ctrl_q <= {CTRL_W{1'b0}};
      m_data_q <= {DATA_W{1'b0}};
      s_ctrl_q <= {CTRL_W{1'b0}};
      s_data_q <= {DATA_W{1'b0}};
    end else begin
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = m_ctrl_q;
  assign out_data  = m_data_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  // Saturating increments: stalls are presented-but-not-taken cycles, flushes
  // only count when they actually discard something.
  always_comb begin
    if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush && (state_q != ST_EMPTY) && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  // Counter width is only meaningful with the counters present; an empty
  // block keeps the parameter referenced in the lean build.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//   Directed stimulus with a scoreboard: accepted entries are queued as the
//   expected response, and a monitor thread pops and compares every entry the
//   stage hands downstream. Directed spot checks cover latency, backpressure,
//   flush, reset and (with PIPE_STAGE_PERF_EN) the counters.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;
  localparam int DW = 96;
  localparam int CW = 13;
  localparam int NW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] flush_cnt;
`endif

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  logic [CW+DW-1:0] sb[$];
  logic [CW+DW-1:0] exp_e;
  logic [CW+DW-1:0] hold_e;
  logic             hold_v;

  function automatic logic [DW-1:0] mk_data(input logic [CW-1:0] c);
    logic [31:0] w;
    w = {19'd0, c};
    mk_data = {32'hDEAD_0000 | w, ~w, 32'h0C0F_FEE0 + w};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c);
    in_valid = v;
    in_ctrl  = c;
    in_data  = mk_data(c);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    hold_v    = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    fork
      // ---------------- stimulus thread ----------------
      begin
        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
`ifdef PIPE_STAGE_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
`endif
        #21 rst = 1'b0;
        #1 chk("rel_in_ready_low", in_ready, 0);
        step();
        chk("rel_in_ready_high", in_ready, 1);

        // Streaming: 10 pushes back to back, one out per cycle
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
          drive(1'b1, CW'(i));
          chk("stream_in_ready", in_ready, 1);
          step();
          chk("stream_out_valid", out_valid, 1);
          chk("stream_out_ctrl", out_ctrl, i);
        end
        drive(1'b0, '0);
        step();
        chk("stream_drained", out_valid, 0);
        chk("stream_bubble_ctrl", out_ctrl, 0);

        // Backpressure: A then B with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 13'h0AA);
        step();
        chk("bp_a_valid", out_valid, 1);
        chk("bp_a_ctrl", out_ctrl, 13'h0AA);
        chk("bp_ready_after_a", in_ready, 1);
        drive(1'b1, 13'h0BB);
        step();
        chk("bp_ready_after_b", in_ready, 0);
        chk("bp_a_held", out_ctrl, 13'h0AA);
        drive(1'b0, '0);
        step();
        step();
        chk("bp_a_still", out_ctrl, 13'h0AA);
        chk("bp_ready_still_low", in_ready, 0);
        out_ready = 1'b1;
        step();
        chk("bp_b_ctrl", out_ctrl, 13'h0BB);
        chk("bp_b_data", out_data, mk_data(13'h0BB));
        chk("bp_ready_back", in_ready, 1);
        step();
        chk("bp_empty", out_valid, 0);

        // Flush from TWO with a same-cycle incoming entry
        out_ready = 1'b0;
        drive(1'b1, 13'h111);
        step();
        drive(1'b1, 13'h122);
        step();
        chk("fl_pre_two", in_ready, 0);
        drive(1'b1, 13'h1CC);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_out_ctrl", out_ctrl, 0);
        chk("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        step();
        chk("fl_no_ghost", out_valid, 0);

        // Reset mid-stream from ONE
        out_ready = 1'b0;
        drive(1'b1, 13'h0DD);
        step();
        drive(1'b0, '0);
        chk("mr_one", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_out_ctrl", out_ctrl, 0);
        chk("mr_out_data", out_data, 0);
        chk("mr_in_ready", in_ready, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("mr_rel_ready_low", in_ready, 0);
        step();
        chk("mr_rel_ready_high", in_ready, 1);
        chk("mr_still_empty", out_valid, 0);

`ifdef PIPE_STAGE_PERF_EN
        // Performance counters (CNT_W=4 saturates at 15)
        chk("perf_stall_clear", stall_cnt, 0);
        drive(1'b1, 13'h0E1);
        step();
        drive(1'b0, '0);
        for (int k = 0; k < 20; k++) step();
        chk("perf_stall_sat", stall_cnt, 15);
        for (int k = 0; k < 3; k++) begin
          if (k > 0) begin
            drive(1'b1, CW'(13'h0F0 + k));
            step();
            drive(1'b0, '0);
          end
          flush = 1'b1;
          step();
          flush = 1'b0;
        end
        chk("perf_flush_3", flush_cnt, 3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("perf_flush_empty", flush_cnt, 3);
`endif

        out_ready = 1'b1;
        step();
        step();
        chk("sb_drained", sb.size(), 0);
      end
      // ---------------- monitor / scoreboard thread ----------------
      begin
        forever begin
          @(negedge clk);
          if (rst) begin
            sb.delete();
            hold_v = 1'b0;
          end else begin
            if (hold_v) begin
              chk("hold_valid", out_valid, 1);
              chk("hold_entry", {out_ctrl, out_data}, hold_e);
            end
            if (!out_valid) chk("bubble_ctrl", out_ctrl, 0);
            hold_v = out_valid && !out_ready && !flush;
            hold_e = {out_ctrl, out_data};
            if (flush) begin
              sb.delete();
            end else begin
              if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_unexpected actual=%0h required=none @%0t", out_ctrl, $time);
                end else begin
                  exp_e = sb.pop_front();
                  chk("sb_ctrl", out_ctrl, exp_e[CW+DW-1:DW]);
                  chk("sb_data", out_data, exp_e[DW-1:0]);
                end
              end
              if (in_valid && in_ready) sb.push_back({in_ctrl, in_data});
            end
          end
        end
      end
      // ---------------- watchdog ----------------
      begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish @%0t", $time);
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
